// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle radix-2 multiply/divide unit for the ALU
// MULT/DIV/MULTU/DIVU opcodes. One command at a time through a valid/ready
// handshake; the result is held in DONE until the consumer takes it.
// Signed operations run on magnitudes and apply the result sign in FIX.

module alu_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz,
   output logic             ovf,
   output logic             ill
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_MULT  = 4'ha;
   localparam logic [3:0] OP_DIV   = 4'hb;
   localparam logic [3:0] OP_MULTU = 4'hc;
   localparam logic [3:0] OP_DIVU  = 4'hd;

   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Two's complement negation of a WIDTH-bit value.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return (~v) + ONE_W;
   endfunction

   // Two's complement negation of a 2*WIDTH-bit value.
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return (~v) + ONE_2W;
   endfunction

   state_t             state_r;
   state_t             state_nxt_s;
   logic               in_ready_nxt_s;
   logic               out_valid_nxt_s;

   logic               accept_s;
   logic               is_mul_s;
   logic               is_div_s;
   logic               is_signed_s;
   logic               legal_s;
   logic               dbz_s;
   logic               ovf_s;
   logic [WIDTH-1:0]   abs0_s;
   logic [WIDTH-1:0]   abs1_s;

   logic               is_div_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic [WIDTH-1:0]   b_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_nxt_s;
   logic [WIDTH:0]     div_sh_s;
   logic [WIDTH:0]     div_diff_s;
   logic [2*WIDTH-1:0] div_nxt_s;
   logic [2*WIDTH-1:0] fix_s;

   assign accept_s = in_valid & in_ready;

   // Decode the incoming command and form operand magnitudes.
   always_comb begin
      is_mul_s    = (opcode == OP_MULT) || (opcode == OP_MULTU);
      is_div_s    = (opcode == OP_DIV)  || (opcode == OP_DIVU);
      is_signed_s = (opcode == OP_MULT) || (opcode == OP_DIV);
      legal_s     = is_mul_s || is_div_s;
      dbz_s       = is_div_s && (data1 == ZERO_W);
      ovf_s       = (opcode == OP_DIV) && (data0 == MIN_W) && (data1 == ONES_W);
      if (is_signed_s && data0[WIDTH-1]) begin
         abs0_s = neg_w(data0);
      end else begin
         abs0_s = data0;
      end
      if (is_signed_s && data1[WIDTH-1]) begin
         abs1_s = neg_w(data1);
      end else begin
         abs1_s = data1;
      end
   end

   // One radix-2 iteration for multiply (shift-add) and divide (restoring).
   always_comb begin
      if (acc_r[0]) begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      mul_nxt_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
      div_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s = div_sh_s - {1'b0, b_r};
      if (div_diff_s[WIDTH]) begin
         div_nxt_s = {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
         div_nxt_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction: product/quotient follow operand signs, remainder follows dividend.
   always_comb begin
      fix_s = acc_r;
      if (is_div_r) begin
         if (neg_r_r) begin
            fix_s[2*WIDTH-1:WIDTH] = neg_w(acc_r[2*WIDTH-1:WIDTH]);
         end else begin
            fix_s[2*WIDTH-1:WIDTH] = acc_r[2*WIDTH-1:WIDTH];
         end
         if (neg_q_r) begin
            fix_s[WIDTH-1:0] = neg_w(acc_r[WIDTH-1:0]);
         end else begin
            fix_s[WIDTH-1:0] = acc_r[WIDTH-1:0];
         end
      end else begin
         if (neg_q_r) begin
            fix_s = neg_2w(acc_r);
         end else begin
            fix_s = acc_r;
         end
      end
   end

   // State register plus registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         in_ready  <= in_ready_nxt_s;
         out_valid <= out_valid_nxt_s;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (legal_s && !dbz_s) begin
                  state_nxt_s = ST_BUSY;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_FIX: begin
            state_nxt_s = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the next state so they register cleanly.
   always_comb begin
      in_ready_nxt_s  = 1'b0;
      out_valid_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE: in_ready_nxt_s  = 1'b1;
         ST_DONE: out_valid_nxt_s = 1'b1;
         default: begin
            in_ready_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Operand latch, iteration counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         b_r      <= ZERO_W;
         acc_r    <= {ZERO_W, ZERO_W};
         cnt_r    <= CNT_ZERO;
      end else if (accept_s) begin
         is_div_r <= is_div_s;
         neg_q_r  <= is_signed_s & (data0[WIDTH-1] ^ data1[WIDTH-1]);
         neg_r_r  <= is_signed_s & data0[WIDTH-1];
         b_r      <= is_div_s ? abs1_s : abs0_s;
         acc_r    <= {ZERO_W, (is_div_s ? abs0_s : abs1_s)};
         cnt_r    <= CNT_ZERO;
      end else if (state_r == ST_BUSY) begin
         acc_r <= is_div_r ? div_nxt_s : mul_nxt_s;
         if (cnt_r != CNT_LAST) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   // Result and flag registers: loaded at accept (short-cut cases) or in FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi  <= ZERO_W;
         lo  <= ZERO_W;
         dbz <= 1'b0;
         ovf <= 1'b0;
         ill <= 1'b0;
      end else if (accept_s) begin
         dbz <= dbz_s;
         ovf <= ovf_s;
         ill <= ~legal_s;
         if (!legal_s) begin
            hi <= ZERO_W;
            lo <= ZERO_W;
         end else if (dbz_s) begin
            hi <= data0;
            lo <= ONES_W;
         end else begin
            hi <= hi;
            lo <= lo;
         end
      end else if (state_r == ST_FIX) begin
         hi <= fix_s[2*WIDTH-1:WIDTH];
         lo <= fix_s[WIDTH-1:0];
      end else begin
         hi <= hi;
         lo <= lo;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed testbench for alu_muldiv_seq (WIDTH=32) with hand-computed results.

module tb_alu_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [31:0] data0;
   logic [31:0] data1;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dbz;
   logic        ovf;
   logic        ill;

   int n_checks = 0;
   int n_pass   = 0;

   alu_muldiv_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .data0     (data0),
      .data1     (data1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hi        (hi),
      .lo        (lo),
      .dbz       (dbz),
      .ovf       (ovf),
      .ill       (ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it differs.
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, measure latency, check results, optionally stall, then consume.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input logic e_dbz, input logic e_ovf, input logic e_ill,
                         input int e_lat, input int stall);
      int lat;
      check({tag, ".rdy_pre"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      opcode   = op;
      data0    = d0;
      data1    = d1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, ".lat"}, 64'(lat), 64'(e_lat));
      check({tag, ".hi"},  64'(hi), 64'(e_hi));
      check({tag, ".lo"},  64'(lo), 64'(e_lo));
      check({tag, ".flags"}, 64'({dbz, ovf, ill}), 64'({e_dbz, e_ovf, e_ill}));
      check({tag, ".rdy_done"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         opcode   = 4'hd;
         data0    = 32'h0000_0064;
         data1    = 32'h0000_0003;
         tick();
         check({tag, ".hold"}, {out_valid, in_ready, 30'd0, hi ^ lo},
               {1'b1, 1'b0, 30'd0, e_hi ^ e_lo});
         check({tag, ".hold_lo"}, 64'(lo), 64'(e_lo));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".consumed"}, 64'({out_valid, in_ready}), 64'b01);
      if (stall > 0) begin
         tick();
         check({tag, ".no_overlap"}, 64'({out_valid, in_ready}), 64'b01);
      end
   endtask

   initial begin
      logic seen_valid;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = 4'h0;
      data0     = 32'd0;
      data1     = 32'd0;
      #23;
      check("reset", {in_ready, out_valid, dbz, ovf, ill, 27'd0, hi | lo},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'd0, 32'd0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      run_op("mult_m3x7", 4'ha, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("multu_max", 4'hc, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("mult_m1m1", 4'ha, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("multu_sh4", 4'hc, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("div_m7_2", 4'hb, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("divu_7_2", 4'hd, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("div_7_m2", 4'hb, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("div_m100_7", 4'hb, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("divu_max_1", 4'hd, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
             1'b0, 1'b0, 1'b0, 34, 0);
      run_op("div_ovf", 4'hb, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
             1'b0, 1'b1, 1'b0, 34, 0);
      run_op("divu_dbz", 4'hd, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF,
             1'b1, 1'b0, 1'b0, 1, 0);
      run_op("div_dbz", 4'hb, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
             1'b1, 1'b0, 1'b0, 1, 0);
      run_op("ill_3", 4'h3, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000,
             1'b0, 1'b0, 1'b1, 1, 0);
      run_op("ill_e", 4'he, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
             1'b0, 1'b0, 1'b1, 1, 0);
      run_op("stall", 4'hc, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E,
             1'b0, 1'b0, 1'b0, 34, 5);

      // Reset during BUSY: no result may appear, next command must be correct.
      in_valid = 1'b1;
      opcode   = 4'ha;
      data0    = 32'h0000_0009;
      data1    = 32'h0000_0009;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      check("busy_pre_rst", 64'({out_valid, in_ready}), 64'b00);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst", {in_ready, out_valid, dbz, ovf, ill, 27'd0, hi | lo},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'd0, 32'd0});
      tick();
      tick();
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen_valid = seen_valid | out_valid;
      end
      check("no_valid_after_rst", 64'(seen_valid), 64'd0);
      run_op("post_rst", 4'ha, 32'hFFFF_FFFA, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFD6,
             1'b0, 1'b0, 1'b0, 34, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
